systolic_cmd_sequencer: RTL

Command-driven sequencer for the 4-PE systolic array. It accepts host commands (load weights, load biases, compute, drain) over a valid/ready port and forwards operand bytes from a byte stream to the shared array operand bus. It generates the per-PE weight, bias and accumulate enables plus the drain select. It serialises drained 16-bit accumulators into a byte stream with backpressure. It replaces fixed-schedule sequencing with host-paced, stall-tolerant sequencing.

---
 rtl/systolic_cmd_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/systolic_cmd_sequencer.sv
// Command sequencer for the systolic PE chain.
// The host issues load-weight, load-bias, compute and drain commands.
// Operand bytes pass straight through to the shared array bus.
// Per-PE strobes and enables are decoded from the current state and counters.
// Drained accumulators leave as low byte then high byte, with backpressure.
module systolic_cmd_sequencer #(
   parameter int NUM_PE = 4,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 16,
   parameter int LEN_W  = 4,
   localparam int SEL_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic [1:0]        i_cmd_op,
   input  logic [LEN_W-1:0]  i_cmd_len,
   input  logic              i_abort,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [DATA_W-1:0] i_in_data,
   output logic [DATA_W-1:0] o_op_data,
   output logic [NUM_PE-1:0] o_pe_weight_en,
   output logic [NUM_PE-1:0] o_pe_bias_en,
   output logic [NUM_PE-1:0] o_pe_acc_en,
   output logic [SEL_W-1:0]  o_drain_sel,
   input  logic [ACC_W-1:0]  i_acc_in,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [DATA_W-1:0] o_out_data,
   output logic              o_busy,
   output logic              o_done
);

   // The step counter must reach L+NUM_PE-2, where L can be as large as 2^LEN_W.
   localparam int CNT_W = $clog2((1 << LEN_W) + NUM_PE) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_W,
      S_LOAD_B,
      S_COMPUTE,
      S_DR_CAP,
      S_DR_LO,
      S_DR_HI
   } state_t;

   state_t           r_state;
   logic [SEL_W-1:0] r_idx;
   logic [CNT_W-1:0] r_t;
   logic [CNT_W-1:0] r_len;
   logic [ACC_W-1:0] r_hold;

   logic              w_abort;
   logic              w_loading;
   logic              w_lastIdx;
   logic              w_feedPhase;
   logic [CNT_W-1:0]  w_lastT;
   logic              w_inReady;
   logic              w_beat;
   logic              w_computeStep;
   logic              w_outValid;
   logic              w_outFire;
   logic              w_loadDone;
   logic              w_computeDone;
   logic              w_drainDone;
   logic [NUM_PE-1:0] w_idxOneHot;
   logic [NUM_PE-1:0] w_accEn;

   // Abort matters only while a command is in flight.
   assign w_abort       = i_abort && (r_state != S_IDLE);
   assign w_loading     = (r_state == S_LOAD_W) || (r_state == S_LOAD_B);
   assign w_lastIdx     = (r_idx == SEL_W'(NUM_PE - 1));
   assign w_feedPhase   = (r_t < r_len);
   assign w_lastT       = (r_len + CNT_W'(NUM_PE)) - CNT_W'(2);

   // During the abort cycle the array is isolated from the byte streams.
   assign w_inReady     = !w_abort && (w_loading || ((r_state == S_COMPUTE) && w_feedPhase));
   assign w_beat        = w_inReady && i_in_valid;
   assign w_computeStep = (r_state == S_COMPUTE) && !w_abort && (!w_feedPhase || i_in_valid);
   assign w_outValid    = ((r_state == S_DR_LO) || (r_state == S_DR_HI)) && !w_abort;
   assign w_outFire     = w_outValid && i_out_ready;

   assign w_loadDone    = w_loading && w_beat && w_lastIdx;
   assign w_computeDone = w_computeStep && (r_t == w_lastT);
   assign w_drainDone   = (r_state == S_DR_HI) && w_outFire && w_lastIdx;

   assign w_idxOneHot   = NUM_PE'(1) << r_idx;

   // PE i sees stream element t-i, so it accumulates while 0 <= t-i < L.
   always_comb begin
      w_accEn = '0;
      if (w_computeStep) begin
         for (int i = 0; i < NUM_PE; i++) begin
            w_accEn[i] = (r_t >= CNT_W'(i)) && (r_t < (CNT_W'(i) + r_len));
         end
      end
   end

   assign o_cmd_ready    = (r_state == S_IDLE);
   assign o_busy         = (r_state != S_IDLE);
   assign o_in_ready     = w_inReady;
   assign o_op_data      = i_in_data;
   assign o_pe_weight_en = ((r_state == S_LOAD_W) && w_beat) ? w_idxOneHot : '0;
   assign o_pe_bias_en   = ((r_state == S_LOAD_B) && w_beat) ? w_idxOneHot : '0;
   assign o_pe_acc_en    = w_accEn;
   assign o_drain_sel    = (r_state == S_DR_CAP) ? r_idx : '0;
   assign o_out_valid    = w_outValid;
   assign o_out_data     = (r_state == S_DR_HI) ? r_hold[ACC_W-1:DATA_W] : r_hold[DATA_W-1:0];
   assign o_done         = w_loadDone || w_computeDone || w_drainDone;

   // Command FSM: accept in IDLE, advance per beat, step or handshake, and drop back to IDLE on completion or abort.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_t     <= '0;
         r_len   <= '0;
         r_hold  <= '0;
      end else if (w_abort) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_t     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_cmd_valid) begin
                  r_idx <= '0;
                  r_t   <= '0;
                  r_len <= CNT_W'(i_cmd_len) + CNT_W'(1);
                  case (i_cmd_op)
                     2'b00:   r_state <= S_LOAD_W;
                     2'b01:   r_state <= S_LOAD_B;
                     2'b10:   r_state <= S_COMPUTE;
                     default: r_state <= S_DR_CAP;
                  endcase
               end
            end
            S_LOAD_W, S_LOAD_B: begin
               if (w_beat) begin
                  if (w_lastIdx) begin
                     r_state <= S_IDLE;
                     r_idx   <= '0;
                  end else begin
                     r_idx <= r_idx + SEL_W'(1);
                  end
               end
            end
            S_COMPUTE: begin
               if (w_computeStep) begin
                  if (r_t == w_lastT) begin
                     r_state <= S_IDLE;
                     r_t     <= '0;
                  end else begin
                     r_t <= r_t + CNT_W'(1);
                  end
               end
            end
            S_DR_CAP: begin
               r_hold  <= i_acc_in;
               r_state <= S_DR_LO;
            end
            S_DR_LO: begin
               if (i_out_ready) begin
                  r_state <= S_DR_HI;
               end
            end
            S_DR_HI: begin
               if (i_out_ready) begin
                  if (w_lastIdx) begin
                     r_state <= S_IDLE;
                     r_idx   <= '0;
                  end else begin
                     r_idx   <= r_idx + SEL_W'(1);
                     r_state <= S_DR_CAP;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
